oric_membus_ctrl: RTL
=====================

Name: oric_membus_ctrl

Overview:
- Parametrised CPU data-bus steering and memory-access controller for the Oric machine top level.
- Supersedes the fixed priority read mux and hard-wired ROM selection with:
  - NUM_ROM selectable ROM images
  - NUM_SLOT expansion I/O slots
  - a request/acknowledge external-memory handshake with CPU ready stretching and timeout
- Sits between the T65 core, ULA decode strobes, VIA, ROM blocks, expansion devices and the external SRAM/SDRAM port.

Parameters:
- NUM_ROM, 2, number of selectable system ROM images (1..8)
- NUM_SLOT, 2, number of expansion I/O slots (1..4); lower index has higher priority
- ROM_AW, 14, ROM address width per image
- TIMEOUT, 15, max CLK_IN cycles waiting for mem_ack before the access is aborted
- FILL_BYTE, 8'hFF, data returned on timeout or unclaimed read

Ports:
- CLK_IN  in  1  system clock
- RESETn  in  1  asynchronous active-low reset
- PHI2_EN  in  1  one-cycle strobe, start of PHI2 high
- PHI2_EN_N  in  1  one-cycle strobe, end of PHI2 high (CPU data sample point)
- cpu_addr  in  16  CPU address
- cpu_rw  in  1  1 = read
- cpu_do  in  8  CPU write data
- cpu_di  out  8  registered CPU read data
- cpu_rdy  out  1  CPU ready; low stretches the cycle
- rom_sel  in  $clog2(NUM_ROM) (min 1)  active ROM image index
- csio_n, csrom_n, csram_n  in  1 each  ULA chip selects
- map_n, romdis_n  in  1 each  expansion MAP / ROMDIS
- slot_ioctl_n  in  NUM_SLOT  per-slot IOCONTROL claim, active low
- slot_do  in  NUM_SLOT*8  slot read data, slot i at [8i+7:8i]
- via_do  in  8  VIA read data
- rom_do  in  NUM_ROM*8  ROM image data, combinational on cpu_addr[ROM_AW-1:0]
- mem_req  out  1  external memory request
- mem_addr  out  16  external memory address
- mem_we  out  1  write request
- mem_d  out  8  write data
- mem_ack  in  1  one-cycle completion pulse
- mem_q  in  8  read data, valid with mem_ack
- bus_err  out  1  sticky timeout flag
- bus_err_clr  in  1  clears bus_err

Behaviour:
- Reset values of outputs:
  - cpu_di = FILL_BYTE
  - cpu_rdy = 1
  - mem_req = 0, mem_we = 0
  - mem_addr = 0, mem_d = 0
  - bus_err = 0
  - FSM = IDLE
- Source decode is evaluated only on PHI2_EN. Priority, first match wins:
  1. Lowest-index slot with csio_n = 0 and slot_ioctl_n[i] = 0.
  2. VIA: csio_n = 0 and all slot_ioctl_n high.
  3. ROM: csio_n = 1, csrom_n = 0, map_n = 1, romdis_n = 1; image = rom_sel.
  4. RAM: csram_n = 0, or map_n = 0 (overlay).
  5. None: returns FILL_BYTE.
- rom_sel >= NUM_ROM selects image 0. rom_sel is sampled at PHI2_EN; mid-cycle changes are ignored.
- FSM states:
  - IDLE: wait for PHI2_EN, then decode.
  - Read from slot, VIA, ROM or none: go to LOCAL, which captures data into cpu_di on PHI2_EN_N; return to IDLE.
  - RAM read or write: go to REQ.
  - REQ: mem_req = 1 for exactly one cycle. mem_addr = cpu_addr, mem_we = ~cpu_rw, mem_d = cpu_do are latched. Go to WAIT.
  - WAIT: count cycles (5-bit counter).
    - On mem_ack: cpu_di <= mem_q (reads only), cpu_rdy <= 1, go to IDLE.
    - If PHI2_EN_N arrives before mem_ack: cpu_rdy <= 0 until ack.
    - Counter reaching TIMEOUT: cpu_di <= FILL_BYTE, bus_err <= 1, cpu_rdy <= 1, go to IDLE. A later stray mem_ack in IDLE is ignored.
- mem_ack in the same cycle as REQ is legal; it completes with zero wait.
- Writes to slot, VIA or ROM regions: no bus action here; devices decode writes themselves. Write cycles leave cpu_di unchanged.
- PHI2_EN while not in IDLE (stretched cycle): deferred; decode occurs at the first PHI2_EN after return to IDLE.
- bus_err_clr takes priority over a same-cycle timeout set.
- RESETn asserted mid-access: immediately return to reset values; any outstanding request is abandoned.

Optional Feature:
- OVERLAY_RAM_EN
  - Defined: when romdis_n = 0 and csrom_n = 0 with no slot claim, the access is routed to external memory at mem_addr = cpu_addr, so the 16 KB region under ROM becomes writable overlay RAM (Atmos-style).
  - Undefined: the same condition returns FILL_BYTE on reads and ignores writes.

Decomposition:
- Package oric_bus_pkg:
  - bus_src_e enum {SRC_SLOT, SRC_VIA, SRC_ROM, SRC_RAM, SRC_NONE}
  - membus_state_e {IDLE, LOCAL, REQ, WAIT}
  - FILL_BYTE default constant
- One sub-module, oric_bus_prio_dec: combinational priority decoder producing bus_src_e and slot index.

Test Plan:
- ROM read, rom_sel = 1, addr 16'hC000, rom_do image1 = 8'h4C: cpu_di = 8'h4C after PHI2_EN_N; mem_req never asserted.
- Both slots claim, slot0 = 8'hA5, slot1 = 8'h5A, csio_n = 0: cpu_di = 8'hA5.
- RAM write 16'h0400 = 8'h33, ack 1 cycle after REQ: one mem_req pulse with mem_we = 1, mem_d = 8'h33; cpu_rdy stays 1.
- RAM read with ack 20 cycles late, PHI2_EN_N mid-wait: cpu_rdy low from PHI2_EN_N until ack; cpu_di = mem_q (8'h77).
- No ack, TIMEOUT = 15: cpu_di = 8'hFF and bus_err = 1 at cycle 15; bus_err_clr returns it to 0.
- RESETn low during WAIT: mem_req = 0, cpu_rdy = 1, cpu_di = 8'hFF immediately; next access proceeds normally.

Source files
------------

// File: rtl/oric_bus_pkg.sv
// oric_bus_pkg: shared types and constants for the Oric CPU data-bus controller
package oric_bus_pkg;
  typedef enum logic [2:0] {SRC_SLOT, SRC_VIA, SRC_ROM, SRC_RAM, SRC_NONE} bus_src_e;
  typedef enum logic [1:0] {IDLE, LOCAL, REQ, WAIT} membus_state_e;
  localparam logic [7:0] FILL_BYTE_DEF = 8'hFF;
endpackage

// File: rtl/oric_bus_prio_dec.sv
// oric_bus_prio_dec: priority decode of the CPU cycle source; OVERLAY_RAM_EN maps ROMDIS'd ROM space to external RAM
module oric_bus_prio_dec import oric_bus_pkg::*; #(
  parameter int NUM_SLOT = 2,
  localparam int SW = NUM_SLOT > 1 ? $clog2(NUM_SLOT) : 1
)(
  input  logic                csio_n,
  input  logic                csrom_n,
  input  logic                csram_n,
  input  logic                map_n,
  input  logic                romdis_n,
  input  logic [NUM_SLOT-1:0] slot_ioctl_n,
  output bus_src_e            src,
  output logic [SW-1:0]       slot
);
  // first match wins; the slot scan runs high to low so the lowest claiming index survives
  always_comb begin
    src = SRC_NONE;
    slot = '0;
    if (!csio_n && !(&slot_ioctl_n)) begin
      src = SRC_SLOT;
      for (int i = NUM_SLOT - 1; i >= 0; i--)
        if (!slot_ioctl_n[i]) slot = SW'(i);
    end
    else if (!csio_n) src = SRC_VIA;
    else if (!csrom_n && map_n && romdis_n) src = SRC_ROM;
    else if (!csram_n || !map_n) src = SRC_RAM;
`ifdef OVERLAY_RAM_EN
    else if (!csrom_n && !romdis_n) src = SRC_RAM;
`endif
  end
endmodule

// File: rtl/oric_membus_ctrl.sv
// oric_membus_ctrl: CPU read steering and external memory handshake with ready stretch and timeout (OVERLAY_RAM_EN selects ROM-shadow RAM)
module oric_membus_ctrl import oric_bus_pkg::*; #(
  parameter int          NUM_ROM   = 2,
  parameter int          NUM_SLOT  = 2,
  parameter int          ROM_AW    = 14,
  parameter int          TIMEOUT   = 15,
  parameter logic [7:0]  FILL_BYTE = FILL_BYTE_DEF,
  localparam int         RSW = NUM_ROM > 1 ? $clog2(NUM_ROM) : 1,
  localparam int         SW  = NUM_SLOT > 1 ? $clog2(NUM_SLOT) : 1
)(
  input  logic                  CLK_IN,
  input  logic                  RESETn,
  input  logic                  PHI2_EN,
  input  logic                  PHI2_EN_N,
  input  logic [15:0]           cpu_addr,
  input  logic                  cpu_rw,
  input  logic [7:0]            cpu_do,
  output logic [7:0]            cpu_di,
  output logic                  cpu_rdy,
  input  logic [RSW-1:0]        rom_sel,
  input  logic                  csio_n,
  input  logic                  csrom_n,
  input  logic                  csram_n,
  input  logic                  map_n,
  input  logic                  romdis_n,
  input  logic [NUM_SLOT-1:0]   slot_ioctl_n,
  input  logic [NUM_SLOT*8-1:0] slot_do,
  input  logic [7:0]            via_do,
  input  logic [NUM_ROM*8-1:0]  rom_do,
  output logic                  mem_req,
  output logic [15:0]           mem_addr,
  output logic                  mem_we,
  output logic [7:0]            mem_d,
  input  logic                  mem_ack,
  input  logic [7:0]            mem_q,
  output logic                  bus_err,
  input  logic                  bus_err_clr
);
  if (NUM_ROM < 1 || NUM_ROM > 8 || NUM_SLOT < 1 || NUM_SLOT > 4 ||
      ROM_AW < 1 || ROM_AW > 16 || TIMEOUT < 1 || TIMEOUT > 31) begin : g_bad_param
    $error("oric_membus_ctrl: parameter out of range");
  end
  membus_state_e state, nxt;
  bus_src_e src_d, src_q;
  logic [SW-1:0] slot_d, slot_q;
  logic [RSW-1:0] img_q;
  logic [4:0] cnt;
  logic [7:0] rdat;
  logic busy, tmo, start;
  oric_bus_prio_dec #(.NUM_SLOT(NUM_SLOT)) u_dec (
    .csio_n(csio_n), .csrom_n(csrom_n), .csram_n(csram_n), .map_n(map_n),
    .romdis_n(romdis_n), .slot_ioctl_n(slot_ioctl_n), .src(src_d), .slot(slot_d)
  );
  assign busy = state == REQ || state == WAIT;
  assign start = state == IDLE && PHI2_EN;
  assign tmo = state == WAIT && !mem_ack && cnt >= 5'(TIMEOUT - 1);
  assign mem_req = state == REQ;
  // read data of the source latched at cycle start
  always_comb rdat = src_q == SRC_SLOT ? slot_do[8*slot_q +: 8] :
                     src_q == SRC_VIA  ? via_do :
                     src_q == SRC_ROM  ? rom_do[8*img_q +: 8] : FILL_BYTE;
  // state register
  always_ff @(posedge CLK_IN or negedge RESETn)
    if (!RESETn) state <= IDLE;
    else state <= nxt;
  // next state: local reads wait for the sample strobe, RAM goes through the handshake
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  nxt = !PHI2_EN ? IDLE : src_d == SRC_RAM ? REQ : cpu_rw ? LOCAL : IDLE;
      LOCAL: nxt = PHI2_EN_N ? IDLE : LOCAL;
      REQ:   nxt = mem_ack ? IDLE : WAIT;
      WAIT:  nxt = mem_ack || tmo ? IDLE : WAIT;
    endcase
  end
  // cycle capture, memory request latching, read data, ready stretch and error flag
  always_ff @(posedge CLK_IN or negedge RESETn)
    if (!RESETn) begin
      src_q <= SRC_NONE;
      slot_q <= '0;
      img_q <= '0;
      cnt <= '0;
      cpu_di <= FILL_BYTE;
      cpu_rdy <= 1'b1;
      mem_addr <= '0;
      mem_we <= 1'b0;
      mem_d <= '0;
      bus_err <= 1'b0;
    end else begin
      if (start) begin
        src_q <= src_d;
        slot_q <= slot_d;
        img_q <= int'(rom_sel) < NUM_ROM ? rom_sel : '0;
      end
      if (start && src_d == SRC_RAM) begin
        mem_addr <= cpu_addr;
        mem_we <= ~cpu_rw;
        mem_d <= cpu_do;
      end
      cnt <= busy ? cnt + 5'd1 : '0;
      if (state == LOCAL && PHI2_EN_N) cpu_di <= rdat;
      else if (busy && mem_ack && !mem_we) cpu_di <= mem_q;
      else if (tmo) cpu_di <= FILL_BYTE;
      if (busy && (mem_ack || tmo)) cpu_rdy <= 1'b1;
      else if (busy && PHI2_EN_N) cpu_rdy <= 1'b0;
      bus_err <= bus_err_clr ? 1'b0 : tmo ? 1'b1 : bus_err;
    end
endmodule
